// File: rtl/postfix_evaluator_pkg.sv
// rtl/postfix_evaluator_pkg.sv - operator codes, error codes and FSM states for the postfix evaluator
package math_pkg;

    localparam int OP_ADD  = 43;
    localparam int OP_SUB  = 45;
    localparam int OP_MUL  = 42;
    localparam int OP_LPAR = 40;
    localparam int OP_RPAR = 41;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_BADOP     = 3'd3,
        ERR_UNBAL     = 3'd4
    } err_t;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_EXEC,
        ST_DRAIN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/postfix_evaluator_if.sv
// rtl/postfix_evaluator_if.sv - token input stream and result handshake of the postfix evaluator
interface postfix_evaluator_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tok_valid;
    logic                  tok_ready;
    logic                  tok_is_op;
    logic [DATA_WIDTH-1:0] tok_data;
    logic                  tok_last;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [2:0]            error;

    modport master (
        output tok_valid, tok_is_op, tok_data, tok_last, res_ready,
        input  tok_ready, res_valid, result, error
    );

    modport slave (
        input  tok_valid, tok_is_op, tok_data, tok_last, res_ready,
        output tok_ready, res_valid, result, error
    );
endinterface

// File: rtl/postfix_evaluator_stack.sv
// rtl/postfix_evaluator_stack.sv - register-array LIFO with depth counter and pop2/push1 update
module eval_stack #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  STACK_DEPTH = 8,
    localparam int PTR_W       = $clog2(STACK_DEPTH),
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop2_push1,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] top,
    output logic [DATA_WIDTH-1:0] next,
    output logic                  full,
    output logic                  ge2,
    output logic                  eq1,
    output logic [CNT_W-1:0]      depth
);
    // Rounded up to a power of two so every pointer value indexes a real entry.
    logic [DATA_WIDTH-1:0] mem [2**PTR_W];
    logic [CNT_W-1:0]      cnt;
    logic [PTR_W-1:0]      top_idx;
    logic [PTR_W-1:0]      next_idx;

    assign top_idx  = PTR_W'(cnt - CNT_W'(1));
    assign next_idx = PTR_W'(cnt - CNT_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (push) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop2_push1) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[PTR_W'(cnt)] <= wdata;
        end else if (pop2_push1) begin
            mem[next_idx] <= wdata;
        end
    end

    assign top   = mem[top_idx];
    assign next  = mem[next_idx];
    assign full  = (cnt == CNT_W'(STACK_DEPTH));
    assign ge2   = (cnt >= CNT_W'(2));
    assign eq1   = (cnt == CNT_W'(1));
    assign depth = cnt;

endmodule

// File: rtl/postfix_evaluator.sv
// rtl/postfix_evaluator.sv - streaming postfix expression evaluator: FSM, ALU and sticky error
module postfix_evaluator
    import math_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    postfix_evaluator_if.slave bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    state_t                state;
    err_t                  err;
    err_t                  tok_err;
    logic [DATA_WIDTH-1:0] op_q;
    logic                  last_q;
    logic                  tok_ready_q;
    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] next;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full;
    logic                  ge2;
    logic                  eq1;
    logic [CNT_W-1:0]      depth;
    logic                  xfer;
    logic                  op_ok;
    logic                  push;
    logic                  pop2;
    logic                  clr;

    assign xfer = bus.tok_valid && tok_ready_q;

    always_comb begin
        op_ok = 1'b0;
        case (bus.tok_data)
            DATA_WIDTH'(OP_ADD), DATA_WIDTH'(OP_SUB), DATA_WIDTH'(OP_MUL): op_ok = 1'b1;
            DATA_WIDTH'(OP_LPAR), DATA_WIDTH'(OP_RPAR):                   op_ok = 1'b0;
            default:                                                      op_ok = 1'b0;
        endcase
    end

    // Bad opcode takes priority over underflow for operator tokens.
    always_comb begin
        tok_err = ERR_NONE;
        if (!bus.tok_is_op) begin
            if (full) tok_err = ERR_OVERFLOW;
        end else if (!op_ok) begin
            tok_err = ERR_BADOP;
        end else if (!ge2) begin
            tok_err = ERR_UNDERFLOW;
        end
    end

    always_comb begin
        alu = '0;
        case (op_q)
            DATA_WIDTH'(OP_ADD): alu = next + top;
            DATA_WIDTH'(OP_SUB): alu = next - top;
            DATA_WIDTH'(OP_MUL): alu = next * top;
            default:             alu = '0;
        endcase
    end

    assign push  = (state == ST_ACCEPT) && xfer && (tok_err == ERR_NONE) && !bus.tok_is_op;
    assign pop2  = (state == ST_EXEC);
    assign clr   = (state == ST_RESULT) && bus.res_ready;
    assign wdata = pop2 ? alu : bus.tok_data;

    eval_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop2_push1(pop2),
        .clear     (clr),
        .wdata     (wdata),
        .top       (top),
        .next      (next),
        .full      (full),
        .ge2       (ge2),
        .eq1       (eq1),
        .depth     (depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACCEPT;
            err         <= ERR_NONE;
            op_q        <= '0;
            last_q      <= 1'b0;
            tok_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    tok_ready_q <= 1'b1;
                    if (xfer) begin
                        if (tok_err != ERR_NONE) begin
                            err <= tok_err;
                            if (bus.tok_last) begin
                                state       <= ST_RESULT;
                                tok_ready_q <= 1'b0;
                                res_valid_q <= 1'b1;
                                result_q    <= '0;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else if (bus.tok_is_op) begin
                            op_q        <= bus.tok_data;
                            last_q      <= bus.tok_last;
                            state       <= ST_EXEC;
                            tok_ready_q <= 1'b0;
                        end else if (bus.tok_last) begin
                            state       <= ST_RESULT;
                            tok_ready_q <= 1'b0;
                            res_valid_q <= 1'b1;
                            // The pushed operand is the sole entry only if the stack was empty.
                            if (!ge2 && !eq1) begin
                                result_q <= bus.tok_data;
                            end else begin
                                err      <= ERR_UNBAL;
                                result_q <= '0;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    if (last_q) begin
                        state       <= ST_RESULT;
                        res_valid_q <= 1'b1;
                        if (depth == CNT_W'(2)) begin
                            result_q <= alu;
                        end else begin
                            err      <= ERR_UNBAL;
                            result_q <= '0;
                        end
                    end else begin
                        state       <= ST_ACCEPT;
                        tok_ready_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && bus.tok_last) begin
                        state       <= ST_RESULT;
                        tok_ready_q <= 1'b0;
                        res_valid_q <= 1'b1;
                        result_q    <= '0;
                    end
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        state       <= ST_ACCEPT;
                        tok_ready_q <= 1'b1;
                        res_valid_q <= 1'b0;
                        result_q    <= '0;
                        err         <= ERR_NONE;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    assign bus.tok_ready = tok_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.error     = err;

endmodule

// File: tb/tb_postfix_evaluator.sv
// tb/tb_postfix_evaluator.sv - directed self-checking bench for postfix_evaluator
module tb_postfix_evaluator;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic          is_op;
        logic [DW-1:0] data;
    } tok_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_assert;
    int   n_fail;

    logic [DW-1:0] exp_r_q[$];
    logic [2:0]    exp_e_q[$];

    postfix_evaluator_if #(.DATA_WIDTH(DW)) bus ();

    postfix_evaluator #(
        .DATA_WIDTH (DW),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void parse(input string s, output tok_t q[$]);
        int i;
        int v;
        i = 0;
        q.delete();
        while (i < s.len()) begin
            if (s.getc(i) == 8'd32) begin
                i++;
            end else if (s.getc(i) >= 8'd48 && s.getc(i) <= 8'd57) begin
                v = 0;
                while (i < s.len() && s.getc(i) >= 8'd48 && s.getc(i) <= 8'd57) begin
                    v = v * 10 + int'(s.getc(i)) - 48;
                    i++;
                end
                q.push_back('{is_op: 1'b0, data: DW'(v)});
            end else begin
                q.push_back('{is_op: 1'b1, data: DW'(s.getc(i))});
                i++;
            end
        end
    endfunction

    // Reference evaluation: plain stack arithmetic, sticky first error, per-token cycle cost.
    function automatic void model(input tok_t t[$], output logic [DW-1:0] r, output logic [2:0] e,
                                  output int lat, output int ncyc);
        logic [DW-1:0] st[$];
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int c;
        e = 0; ncyc = 0; lat = 1;
        foreach (t[i]) begin
            c = 1;
            if (e == 0) begin
                if (!t[i].is_op) begin
                    if (st.size() == DEPTH) e = 2;
                    else st.push_back(t[i].data);
                end else if (t[i].data == 43 || t[i].data == 45 || t[i].data == 42) begin
                    if (st.size() < 2) begin
                        e = 1;
                    end else begin
                        b = st.pop_back();
                        a = st.pop_back();
                        if (t[i].data == 43)      st.push_back(DW'(a + b));
                        else if (t[i].data == 45) st.push_back(DW'(a - b));
                        else                      st.push_back(DW'(a * b));
                        c = 2;
                    end
                end else begin
                    e = 3;
                end
            end
            ncyc += c;
            lat = c;
        end
        if (e == 0 && st.size() != 1) e = 4;
        r = (e != 0) ? '0 : st[st.size()-1];
    endfunction

    task automatic send(input tok_t t[$], input bit with_last, output int first_c, output int last_c);
        int k;
        first_c = 0;
        last_c  = 0;
        foreach (t[i]) begin
            k = 0;
            while (!bus.tok_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("tok_ready_wait", int'(bus.tok_ready), 1);
            bus.tok_valid = 1'b1;
            bus.tok_is_op = t[i].is_op;
            bus.tok_data  = t[i].data;
            bus.tok_last  = with_last && (i == t.size() - 1);
            if (i == 0) first_c = cyc;
            last_c = cyc;
            @(negedge clk);
        end
        bus.tok_valid = 1'b0;
        bus.tok_last  = 1'b0;
    endtask

    task automatic run_expr(input string name, input string s, input int exp_r, input int exp_e,
                            input int exp_ncyc, input int hold);
        tok_t          t[$];
        logic [DW-1:0] mr;
        logic [2:0]    me;
        int            lat, ncyc, f, l, k;
        parse(s, t);
        model(t, mr, me, lat, ncyc);
        check({name, "_model_result"}, int'(mr), exp_r);
        check({name, "_model_error"}, int'(me), exp_e);
        if (exp_ncyc >= 0) check({name, "_model_cycles"}, ncyc, exp_ncyc);
        exp_r_q.push_back(mr);
        exp_e_q.push_back(me);
        bus.res_ready = (hold == 0);
        send(t, 1'b1, f, l);
        k = 0;
        while (!bus.res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_res_valid"}, int'(bus.res_valid), 1);
        check({name, "_latency"}, cyc - l, lat);
        check({name, "_cycles"}, cyc - f, ncyc);
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check({name, "_res_valid_after"}, int'(bus.res_valid), 0);
        check({name, "_tok_ready_after"}, int'(bus.tok_ready), 1);
    endtask

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.res_valid) begin
                check("res_valid_expected", int'(exp_r_q.size() > 0), 1);
                if (exp_r_q.size() > 0) begin
                    check("result", int'(bus.result), int'(exp_r_q[0]));
                    check("error", int'(bus.error), int'(exp_e_q[0]));
                    check("tok_ready_in_result", int'(bus.tok_ready), 0);
                    if (bus.res_ready) begin
                        void'(exp_r_q.pop_front());
                        void'(exp_e_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        tok_t t[$];
        int   f, l;
        cyc           = 0;
        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
        bus.tok_last  = 1'b0;
        bus.res_ready = 1'b1;

        @(negedge clk);
        check("rst_tok_ready", int'(bus.tok_ready), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_error", int'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_expr("main",      "5 4 2 - 1 + * 6 -",  9,   0, 13, 0);
        run_expr("wrap_add",  "200 100 +",          44,  0, -1, 0);
        run_expr("wrap_sub",  "3 5 -",              254, 0, -1, 0);
        run_expr("wrap_mul",  "16 16 *",            0,   0, -1, 0);
        run_expr("underflow", "+ 1",                0,   1, 2,  0);
        run_expr("overflow",  "1 2 3 4 5 6 7 8 9",  0,   2, 9,  0);
        run_expr("badop_lp",  "1 2 (",              0,   3, -1, 0);
        run_expr("badop_rp",  "1 2 )",              0,   3, -1, 0);
        run_expr("first_err", "1 ( 2 2 2 2 2 2 2 2 +", 0, 3, -1, 0);
        run_expr("unbal",     "1 2",                0,   4, -1, 0);
        run_expr("hold",      "4 5 +",              9,   0, -1, 5);
        run_expr("after_hold","7",                  7,   0, 1,  0);
        run_expr("chain",     "255 1 + 3 *",        0,   0, -1, 0);

        parse("1 2 3", t);
        send(t, 1'b0, f, l);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tok_ready", int'(bus.tok_ready), 0);
        check("midrst_res_valid", int'(bus.res_valid), 0);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_error", int'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_expr("post_rst",  "2 3 *",              6,   0, -1, 0);

        repeat (3) @(negedge clk);
        check("pending_results", exp_r_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/postfix_evaluator.md
# postfix_evaluator

Streaming consumer of the postfix token stream that the infix-to-postfix converter produces. It accepts one token per handshake, evaluates the expression on an internal LIFO, and presents a single result word with an error code once the last token has been consumed. It sits directly downstream of the converter and replaces the combinational stack ALU for long or back-to-back expressions.

## Interface
- DATA_WIDTH, 8: width of operand tokens, the stack and the result.
- STACK_DEPTH, 8: number of LIFO entries; must be at least 2.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- tok_valid  in  1  token present on tok_data.
- tok_ready  out  1  evaluator can accept a token this cycle.
- tok_is_op  in  1  1: tok_data is an ASCII operator; 0: tok_data is an unsigned operand.
- tok_data  in  DATA_WIDTH  operand value or operator code.
- tok_last  in  1  final token of the expression.
- res_valid  out  1  result and error are valid.
- res_ready  in  1  downstream accepts the result.
- result  out  DATA_WIDTH  evaluated value; 0 when error is nonzero.
- error  out  3  0 OK, 1 underflow, 2 overflow, 3 bad operator, 4 unbalanced final stack.

## Operation
- A token transfers when tok_valid and tok_ready are both 1.
- Operators: '+' (43) adds, '-' (45) subtracts, '*' (42) multiplies. Every other code, including '(' (40) and ')' (41), is a bad operator.
- Operands: pushed onto the stack. If the stack already holds STACK_DEPTH entries, the token raises overflow.
- Operators: pop b (top), then a (next); push a op b. Fewer than 2 entries raises underflow.
- Arithmetic is modulo 2^DATA_WIDTH, so sums, differences and products keep only the low DATA_WIDTH bits. Subtraction wraps.
- FSM states:
  - ACCEPT: tok_ready=1.
    - Operand → push and stay in ACCEPT, or go to RESULT if tok_last.
    - Operator → latch the opcode and go to EXEC.
    - Error → go to DRAIN, or to RESULT if tok_last.
  - EXEC: tok_ready=0. Perform pop2/push1, then go to ACCEPT, or to RESULT if the latched last flag is set.
  - DRAIN: tok_ready=1. Tokens are discarded until tok_last transfers, then go to RESULT.
  - RESULT: res_valid=1 and outputs stay stable until res_ready.
    - On the handshake: clear the stack, clear the error, go to ACCEPT.
    - On entry with no prior error and depth≠1: error=4, result=0.
    - Otherwise result is the top of stack.
- The first error wins and is held. Later tokens of that expression never change error.
- A tok_last token that itself errors still ends the expression.

## Timing
- Reset values: tok_ready=0 while RST_N is low, then 1 (ACCEPT) after reset. res_valid=0, result=0, error=0, stack depth=0.
- Operand throughput is 1 token per cycle. An operator occupies 2 cycles: the accept cycle plus EXEC.
- Result latency:
  - res_valid rises 1 cycle after a last operand transfers.
  - res_valid rises 2 cycles after a last operator transfers.
  - res_valid rises 1 cycle after the tok_last transfer in DRAIN.
- Back-to-back expressions: tok_ready is 0 throughout RESULT and returns to 1 the cycle after the res_ready handshake.
- res_ready held high: RESULT lasts exactly 1 cycle.
- An RST_N assertion mid-expression or mid-RESULT abandons all state immediately. No partial result is emitted.

## Structure
- Shared package math_pkg holds:
  - operator constants OP_ADD=43, OP_SUB=45, OP_MUL=42, OP_LPAR=40, OP_RPAR=41;
  - the error enum (ERR_NONE, ERR_UNDERFLOW, ERR_OVERFLOW, ERR_BADOP, ERR_UNBAL);
  - the FSM state enum.
- Sub-module eval_stack is a register-array LIFO with a depth counter and these ports:
  - push, pop2_push1, clear;
  - top and next read ports;
  - full, depth≥2 and depth==1 flags.
- The evaluator holds the FSM, the opcode/last latches, the ALU and the error register.

## Test plan
- Stream 5 4 2 - 1 + * 6 - (ops flagged, last on the final '-'), with res_ready=1 → result=9, error=0, res_valid 2 cycles after the final '-' transfer, and 13 transfer-cycles total.
- Stream 200 100 + last → result=44 (wrap). Stream 3 5 - last → result=254. Stream 16 16 * last → result=0.
- Stream + 1 last → error=1 on the first token, DRAIN swallows the "1", then result=0 and error=1. With STACK_DEPTH=8, push 9 operands → error=2.
- Stream 1 2 ( last → error=3. Stream 1 2 last → error=4 and result=0.
- Hold res_ready=0 for 5 cycles → result and error stay stable and tok_ready=0. On release, a second expression 7 last → result=7.
- Assert RST_N low after 3 tokens → all outputs return to reset values. A fresh expression 2 3 * last then evaluates to 6.
